// File: rtl/rx_fifo.sv
// Receive FIFO for one UART channel: first-word fall-through character buffer with
// per-entry line status, sticky overrun, errored-entry tracking and level/timeout interrupts.
module rx_fifo #(
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 640
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  uart_write,
   input  logic [7:0]            uart_data,
   input  logic                  uart_perr,
   input  logic                  uart_ferr,
   input  logic                  uart_brk,
   input  logic                  cpu_read,
   output logic [7:0]            cpu_data,
   output logic                  cpu_perr,
   output logic                  cpu_ferr,
   output logic                  cpu_brk,
   input  logic                  cpu_lsr_read,
   input  logic                  cpu_flush,
   input  logic [1:0]            rx_trig,
   output logic                  rx_full,
   output logic                  rx_empty,
   output logic [ADDR_WIDTH:0]   rx_count,
   output logic                  rx_overrun,
   output logic                  rx_err_any,
   output logic                  irq_data,
   output logic                  irq_timeout
);

   localparam int PTR_W = ADDR_WIDTH + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] ZERO_P   = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] ONE_P    = PTR_W'(1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] ZERO_T   = {TMO_W{1'b0}};
   localparam logic [TMO_W-1:0] ONE_T    = TMO_W'(1);

   // An entry is {brk, ferr, perr, data}; any status bit marks it as errored.
   function automatic logic entry_err(input logic [10:0] entry);
      return |entry[10:8];
   endfunction

   logic [10:0]      mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] err_cnt_r;
   logic [TMO_W-1:0] tmo_cnt_r;
   logic             overrun_r;

   logic [PTR_W-1:0] count_s;
   logic [PTR_W-1:0] level_s;
   logic [10:0]      head_s;
   logic [10:0]      wr_entry_s;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic             err_inc_s;
   logic             err_dec_s;

   // Occupancy, accepted push/pop qualification and trigger level decode.
   always_comb begin
      count_s    = wr_ptr_r - rd_ptr_r;
      full_s     = (count_s == DEPTH_C);
      empty_s    = (count_s == ZERO_P);
      push_s     = uart_write & ~full_s & ~cpu_flush;
      pop_s      = cpu_read & ~empty_s & ~cpu_flush;
      head_s     = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
      wr_entry_s = {uart_brk, uart_ferr, uart_perr, uart_data};
      err_inc_s  = push_s & entry_err(wr_entry_s);
      err_dec_s  = pop_s & entry_err(head_s);
      case (rx_trig)
         2'd0:    level_s = ONE_P;
         2'd1:    level_s = PTR_W'(DEPTH / 4);
         2'd2:    level_s = PTR_W'(DEPTH / 2);
         default: level_s = PTR_W'(DEPTH - 2);
      endcase
   end

   // Pointers, error count, idle timer and sticky overrun.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r  <= ZERO_P;
         rd_ptr_r  <= ZERO_P;
         err_cnt_r <= ZERO_P;
         tmo_cnt_r <= ZERO_T;
         overrun_r <= 1'b0;
      end else begin
         // Full is judged before the edge, so a same-cycle pop does not rescue the push.
         if (uart_write && full_s) begin
            overrun_r <= 1'b1;
         end else if (cpu_lsr_read) begin
            overrun_r <= 1'b0;
         end

         if (cpu_flush) begin
            wr_ptr_r  <= ZERO_P;
            rd_ptr_r  <= ZERO_P;
            err_cnt_r <= ZERO_P;
            tmo_cnt_r <= ZERO_T;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + ONE_P;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + ONE_P;
            end
            case ({err_inc_s, err_dec_s})
               2'b10:   err_cnt_r <= err_cnt_r + ONE_P;
               2'b01:   err_cnt_r <= err_cnt_r - ONE_P;
               default: err_cnt_r <= err_cnt_r;
            endcase
            if (push_s || pop_s || empty_s) begin
               tmo_cnt_r <= ZERO_T;
            end else if (tmo_cnt_r != TMO_MAX) begin
               tmo_cnt_r <= tmo_cnt_r + ONE_T;
            end
         end
      end
   end

   // Character storage; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_entry_s;
      end
   end

   assign cpu_data    = empty_s ? 8'h00 : head_s[7:0];
   assign cpu_perr    = ~empty_s & head_s[8];
   assign cpu_ferr    = ~empty_s & head_s[9];
   assign cpu_brk     = ~empty_s & head_s[10];
   assign rx_full     = full_s;
   assign rx_empty    = empty_s;
   assign rx_count    = count_s;
   assign rx_overrun  = overrun_r;
   assign rx_err_any  = (err_cnt_r != ZERO_P);
   assign irq_data    = (count_s >= level_s);
   assign irq_timeout = (tmo_cnt_r == TMO_MAX) & ~empty_s;

endmodule
